// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bundle shared by the arbiter and its requesters.
// master drives requests; slave answers them.
interface axi_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter, one transaction in flight on m.
// Define AXI_ARB_FIXED_PRIO_EN for fixed s0-first priority.
module axi_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rstn,
  axi_intf.slave     s0,
  axi_intf.slave     s1,
  axi_intf.master    m,
  output logic [1:0] grant,
  output logic       busy
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [1:0] grant_nxt;
  logic aw_done;
  logic aw_done_nxt;
  logic w_done;
  logic w_done_nxt;
  logic aw_fire;
  logic w_fire;
  logic req0;
  logic req1;
  logic win1;

  logic [ADDR_WIDTH-1:0] g_awaddr;
  logic [2:0]            g_awprot;
  logic                  g_awvalid;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [STRB_WIDTH-1:0] g_wstrb;
  logic                  g_wvalid;
  logic                  g_bready;
  logic [ADDR_WIDTH-1:0] g_araddr;
  logic [2:0]            g_arprot;
  logic                  g_arvalid;
  logic                  g_rready;

  logic                  p_awready;
  logic                  p_wready;
  logic                  p_bvalid;
  logic [1:0]            p_bresp;
  logic                  p_arready;
  logic                  p_rvalid;
  logic [DATA_WIDTH-1:0] p_rdata;
  logic [1:0]            p_rresp;

  assign req0 = s0.awvalid | s0.arvalid;
  assign req1 = s1.awvalid | s1.arvalid;
  assign busy = (state != IDLE);

`ifdef AXI_ARB_FIXED_PRIO_EN
  assign win1 = req1 & ~req0;
`else
  logic prio1;

  assign win1 = req1 & (~req0 | prio1);

  // Last winner drops to lowest priority
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio1 <= 1'b0;
    end else if (state == IDLE && (req0 | req1)) begin
      prio1 <= ~win1;
    end
  end
`endif

  // State, owner and write-channel progress registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      grant   <= 2'b00;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Select the granted requester's outbound signals
  always_comb begin
    g_awaddr  = '0;
    g_awprot  = '0;
    g_awvalid = 1'b0;
    g_wdata   = '0;
    g_wstrb   = '0;
    g_wvalid  = 1'b0;
    g_bready  = 1'b0;
    g_araddr  = '0;
    g_arprot  = '0;
    g_arvalid = 1'b0;
    g_rready  = 1'b0;
    unique case (1'b1)
      grant[0]: begin
        g_awaddr  = s0.awaddr;
        g_awprot  = s0.awprot;
        g_awvalid = s0.awvalid;
        g_wdata   = s0.wdata;
        g_wstrb   = s0.wstrb;
        g_wvalid  = s0.wvalid;
        g_bready  = s0.bready;
        g_araddr  = s0.araddr;
        g_arprot  = s0.arprot;
        g_arvalid = s0.arvalid;
        g_rready  = s0.rready;
      end
      grant[1]: begin
        g_awaddr  = s1.awaddr;
        g_awprot  = s1.awprot;
        g_awvalid = s1.awvalid;
        g_wdata   = s1.wdata;
        g_wstrb   = s1.wstrb;
        g_wvalid  = s1.wvalid;
        g_bready  = s1.bready;
        g_araddr  = s1.araddr;
        g_arprot  = s1.arprot;
        g_arvalid = s1.arvalid;
        g_rready  = s1.rready;
      end
      default: ;
    endcase
  end

  // Next state, grant and per-phase handshake routing
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    m.awaddr    = g_awaddr;
    m.awprot    = g_awprot;
    m.awvalid   = 1'b0;
    m.wdata     = g_wdata;
    m.wstrb     = g_wstrb;
    m.wvalid    = 1'b0;
    m.bready    = 1'b0;
    m.araddr    = g_araddr;
    m.arprot    = g_arprot;
    m.arvalid   = 1'b0;
    m.rready    = 1'b0;
    p_awready   = 1'b0;
    p_wready    = 1'b0;
    p_bvalid    = 1'b0;
    p_bresp     = 2'b00;
    p_arready   = 1'b0;
    p_rvalid    = 1'b0;
    p_rdata     = '0;
    p_rresp     = 2'b00;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant_nxt = win1 ? 2'b10 : 2'b01;
          if (win1 ? s1.awvalid : s0.awvalid) begin
            state_nxt = WR_ADDR;
          end else begin
            state_nxt = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        m.awvalid   = g_awvalid & ~aw_done;
        m.wvalid    = g_wvalid & ~w_done;
        p_awready   = m.awready & ~aw_done;
        p_wready    = m.wready & ~w_done;
        aw_fire     = g_awvalid & ~aw_done & m.awready;
        w_fire      = g_wvalid & ~w_done & m.wready;
        aw_done_nxt = aw_done | aw_fire;
        w_done_nxt  = w_done | w_fire;
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt   = WR_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      WR_RESP: begin
        m.bready = g_bready;
        p_bvalid = m.bvalid;
        p_bresp  = m.bresp;
        if (m.bvalid && g_bready) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end
      end
      RD_ADDR: begin
        m.arvalid = g_arvalid;
        p_arready = m.arready;
        if (g_arvalid && m.arready) begin
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        m.rready = g_rready;
        p_rvalid = m.rvalid;
        p_rdata  = m.rdata;
        p_rresp  = m.rresp;
        if (m.rvalid && g_rready) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // Return responses only to the owner; the other port sees zeros
  always_comb begin
    s0.awready = grant[0] & p_awready;
    s0.wready  = grant[0] & p_wready;
    s0.bvalid  = grant[0] & p_bvalid;
    s0.bresp   = grant[0] ? p_bresp : 2'b00;
    s0.arready = grant[0] & p_arready;
    s0.rvalid  = grant[0] & p_rvalid;
    s0.rdata   = grant[0] ? p_rdata : '0;
    s0.rresp   = grant[0] ? p_rresp : 2'b00;
    s1.awready = grant[1] & p_awready;
    s1.wready  = grant[1] & p_wready;
    s1.bvalid  = grant[1] & p_bvalid;
    s1.bresp   = grant[1] ? p_bresp : 2'b00;
    s1.arready = grant[1] & p_arready;
    s1.rvalid  = grant[1] & p_rvalid;
    s1.rdata   = grant[1] ? p_rdata : '0;
    s1.rresp   = grant[1] ? p_rresp : 2'b00;
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter.
// Expected grant order follows AXI_ARB_FIXED_PRIO_EN.
module tb_axi_lite_arbiter;
  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] grant;
  logic       busy;
  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  axi_intf s0_if ();
  axi_intf s1_if ();
  axi_intf m_if ();

  axi_lite_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s0(s0_if),
    .s1(s1_if),
    .m(m_if),
    .grant(grant),
    .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.awvalid = 0;
    s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.wvalid = 0;
    s0_if.bready = 0; s0_if.araddr = '0; s0_if.arprot = '0;
    s0_if.arvalid = 0; s0_if.rready = 0;
    s1_if.awaddr = '0; s1_if.awprot = '0; s1_if.awvalid = 0;
    s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.wvalid = 0;
    s1_if.bready = 0; s1_if.araddr = '0; s1_if.arprot = '0;
    s1_if.arvalid = 0; s1_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0;
    m_if.bresp = '0; m_if.arready = 0; m_if.rvalid = 0;
    m_if.rdata = '0; m_if.rresp = '0;
  endtask

  // Called in IDLE with requests set; returns in the next IDLE.
  task automatic serve(input logic [1:0] g, input bit wr,
                       input logic [31:0] rd);
    step();
    check("srv_grant", grant, g);
    check("srv_busy", busy, 1);
    check("srv_iso_awready",
          g[0] ? s1_if.awready : s0_if.awready, 0);
    check("srv_iso_wready",
          g[0] ? s1_if.wready : s0_if.wready, 0);
    if (wr) begin
      check("srv_awvalid", m_if.awvalid, 1);
      check("srv_arvalid_blank", m_if.arvalid, 0);
      check("srv_own_awready",
            g[0] ? s0_if.awready : s1_if.awready, 1);
      step();
      m_if.bvalid = 1;
      m_if.bresp = 2'b00;
      #1;
      check("srv_s0_bvalid", s0_if.bvalid, g[0]);
      check("srv_s1_bvalid", s1_if.bvalid, g[1]);
    end else begin
      check("srv_arvalid", m_if.arvalid, 1);
      check("srv_awvalid_blank", m_if.awvalid, 0);
      step();
      m_if.rvalid = 1;
      m_if.rdata = rd;
      m_if.bvalid = 1;
      #1;
      check("srv_s0_rvalid", s0_if.rvalid, g[0]);
      check("srv_s1_rvalid", s1_if.rvalid, g[1]);
      check("srv_rdata",
            g[0] ? s0_if.rdata : s1_if.rdata, rd);
      check("srv_iso_rdata",
            g[0] ? s1_if.rdata : s0_if.rdata, 0);
      check("srv_iso_bvalid0", s0_if.bvalid, 0);
      check("srv_iso_bvalid1", s1_if.bvalid, 0);
    end
    step();
    m_if.bvalid = 0;
    m_if.rvalid = 0;
    m_if.rdata = '0;
    check("srv_idle_grant", grant, 0);
    check("srv_idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rstn = 0;
    repeat (3) step();
    s0_if.awvalid = 1;
    m_if.awready = 1;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_m_awvalid", m_if.awvalid, 0);
    check("rst_m_arvalid", m_if.arvalid, 0);
    check("rst_s0_awready", s0_if.awready, 0);
    clear_inputs();
    s0_if.bready = 1; s0_if.rready = 1;
    s1_if.bready = 1; s1_if.rready = 1;
    step();
    rstn = 1;
    step();

    // single write from s0
    s0_if.awvalid = 1; s0_if.awaddr = 32'h0000_00FF;
    s0_if.wvalid = 1; s0_if.wdata = 32'h0000_000F;
    s0_if.wstrb = 4'hF;
    m_if.awready = 1; m_if.wready = 1;
    #1;
    check("t1_idle_grant", grant, 0);
    check("t1_idle_awvalid", m_if.awvalid, 0);
    step();
    check("t1_grant", grant, 2'b01);
    check("t1_awvalid", m_if.awvalid, 1);
    check("t1_awaddr", m_if.awaddr, 32'h0000_00FF);
    check("t1_wvalid", m_if.wvalid, 1);
    check("t1_wdata", m_if.wdata, 32'h0000_000F);
    check("t1_wstrb", m_if.wstrb, 4'hF);
    check("t1_s0_awready", s0_if.awready, 1);
    check("t1_s0_wready", s0_if.wready, 1);
    check("t1_s1_awready", s1_if.awready, 0);
    step();
    s0_if.awvalid = 0; s0_if.wvalid = 0;
    check("t1_resp_awvalid", m_if.awvalid, 0);
    check("t1_resp_wvalid", m_if.wvalid, 0);
    check("t1_resp_busy", busy, 1);
    m_if.bvalid = 1; m_if.bresp = 2'b00;
    #1;
    check("t1_s0_bvalid", s0_if.bvalid, 1);
    check("t1_s0_bresp", s0_if.bresp, 2'b00);
    check("t1_m_bready", m_if.bready, 1);
    step();
    m_if.bvalid = 0;
    check("t1_idle_busy", busy, 0);
    check("t1_idle_grant2", grant, 0);

    // split AW/W from s1
    s1_if.awvalid = 1; s1_if.awaddr = 32'h0000_0040;
    step();
    check("t2_grant_c1", grant, 2'b10);
    check("t2_awvalid_c1", m_if.awvalid, 1);
    check("t2_awaddr", m_if.awaddr, 32'h0000_0040);
    check("t2_wvalid_c1", m_if.wvalid, 0);
    check("t2_s1_awready", s1_if.awready, 1);
    check("t2_s0_awready", s0_if.awready, 0);
    step();
    check("t2_awvalid_c2", m_if.awvalid, 0);
    check("t2_s1_awready_c2", s1_if.awready, 0);
    check("t2_grant_c2", grant, 2'b10);
    check("t2_busy_c2", busy, 1);
    step();
    check("t2_bready_c3", m_if.bready, 0);
    s1_if.wvalid = 1; s1_if.wdata = 32'h1234_5678;
    s1_if.wstrb = 4'hF;
    #1;
    check("t2_wvalid_c3", m_if.wvalid, 1);
    check("t2_wdata", m_if.wdata, 32'h1234_5678);
    check("t2_s1_wready", s1_if.wready, 1);
    check("t2_grant_c3", grant, 2'b10);
    step();
    s1_if.awvalid = 0; s1_if.wvalid = 0;
    check("t2_resp_wvalid", m_if.wvalid, 0);
    check("t2_resp_bready", m_if.bready, 1);
    check("t2_resp_grant", grant, 2'b10);
    m_if.bvalid = 1; m_if.bresp = 2'b10;
    #1;
    check("t2_s1_bvalid", s1_if.bvalid, 1);
    check("t2_s1_bresp", s1_if.bresp, 2'b10);
    check("t2_s0_bvalid", s0_if.bvalid, 0);
    check("t2_s0_bresp", s0_if.bresp, 0);
    step();
    m_if.bvalid = 0; m_if.bresp = 2'b00;
    check("t2_idle_grant", grant, 0);

    // simultaneous s0 read / s1 write from reset
    rstn = 0;
    step();
    rstn = 1;
    s0_if.arvalid = 1; s0_if.araddr = 32'h0000_0100;
    s1_if.awvalid = 1; s1_if.awaddr = 32'h0000_0200;
    s1_if.wvalid = 1; s1_if.wdata = 32'h0000_00AA;
    m_if.arready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
      serve(2'b01, 1'b0, 32'h0000_1000 + i);
`else
      if (i % 2 == 0) serve(2'b01, 1'b0, 32'h0000_1000 + i);
      else serve(2'b10, 1'b1, 32'h0);
`endif
    end
    s0_if.arvalid = 0;
    serve(2'b10, 1'b1, 32'h0);
    s1_if.awvalid = 0; s1_if.wvalid = 0;

    // write wins over read inside s0
    s0_if.awvalid = 1; s0_if.awaddr = 32'h0000_0010;
    s0_if.wvalid = 1; s0_if.wdata = 32'h0000_5555;
    s0_if.arvalid = 1; s0_if.araddr = 32'h0000_0020;
    serve(2'b01, 1'b1, 32'h0);
    s0_if.awvalid = 0; s0_if.wvalid = 0;
    serve(2'b01, 1'b0, 32'hDEAD_BEEF);
    s0_if.arvalid = 0;

    // reset while RD_DATA is stalled
    s0_if.arvalid = 1; s0_if.araddr = 32'h0000_0030;
    step();
    check("t5_grant_ar", grant, 2'b01);
    step();
    s0_if.arvalid = 0;
    check("t5_busy_rd", busy, 1);
    check("t5_rready_rd", m_if.rready, 1);
    rstn = 0;
    m_if.rvalid = 1;
    #1;
    check("t5_rst_grant", grant, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rready", m_if.rready, 0);
    check("t5_rst_arvalid", m_if.arvalid, 0);
    check("t5_rst_s0_rvalid", s0_if.rvalid, 0);
    step();
    check("t5_rst_grant2", grant, 0);
    check("t5_rst_busy2", busy, 0);
    rstn = 1;
    m_if.rvalid = 0;
    step();
    check("t5_no_recover", busy, 0);
    s1_if.arvalid = 1; s1_if.araddr = 32'h0000_0050;
    serve(2'b10, 1'b0, 32'hCAFE_F00D);
    s1_if.arvalid = 0;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the AXI address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the AXI data width on all ports; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit, reset: asynchronous assert, active-low.
REQ-005 SHALL have port s0, axi_intf.slave, requester 0, typically the core.
REQ-006 SHALL have port s1, axi_intf.slave, requester 1.
REQ-007 SHALL have port m, axi_intf.master, the shared downstream AXI4-Lite bus to the peripheral.
REQ-008 SHALL have port grant, output, 2 bits, one-hot owner of m (00 = none).
REQ-009 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL use FSM states IDLE, WR_ADDR, WR_RESP, RD_ADDR and RD_DATA, with one transaction in flight on m at a time.
REQ-011 SHALL treat a requester as requesting in IDLE when its awvalid or arvalid is high.
REQ-012 SHALL, in IDLE, register the winner into grant and move to WR_ADDR if the winner's awvalid is high, otherwise to RD_ADDR; write wins over read within a requester.
REQ-013 SHALL arbitrate round-robin: the requester granted last has lowest priority, with s0 first after reset.
REQ-014 SHALL add one cycle of arbitration latency, so m valids are first asserted the cycle after the request is seen in IDLE.
REQ-015 SHALL forward AW and W combinationally from the granted slave port to m in WR_ADDR, with awready and wready returned only to the granted port.
REQ-016 SHALL, in WR_ADDR, track AW and W completion independently (aw_done, w_done), blanking m.awvalid after AW completes and m.wvalid after W completes.
REQ-017 SHALL enter WR_RESP the cycle after both AW and W have completed, including when both complete in the same cycle.
REQ-018 SHALL, in WR_RESP, forward m.bvalid/bresp to the granted port and m.bready from it, and return to IDLE on bvalid&&bready.
REQ-019 SHALL, in RD_ADDR, forward AR, moving to RD_DATA on arvalid&&arready.
REQ-020 SHALL, in RD_DATA, forward rvalid/rdata/rresp and rready, returning to IDLE on rvalid&&rready.
REQ-021 SHALL drive all ready/valid outputs to 0 on the non-granted port in every state, with its data/resp outputs held at 0.
REQ-022 SHALL drive every m valid and ready to 0 in IDLE.
REQ-023 SHALL leave the request of the port not granted pending, with no loss, and serve it in the next arbitration.
REQ-024 SHALL never change grant outside IDLE.

Reset
REQ-025 SHALL, while rstn=0, set the state to IDLE, grant to 00, busy to 0, aw_done/w_done to 0, the round-robin pointer to favour s0, and all valid/ready outputs on s0, s1 and m to 0.
REQ-026 SHALL abandon any in-flight transaction without a response when reset is asserted mid-transaction, with no recovery of it after reset.

Configuration
REQ-027 SHALL, when macro AXI_ARB_FIXED_PRIO_EN is defined, use fixed priority where s0 always wins a simultaneous request and the round-robin pointer is not implemented.
REQ-028 SHALL, when AXI_ARB_FIXED_PRIO_EN is undefined, use the round-robin behaviour of REQ-013.

Verification
REQ-029 SHALL cover a single write: s0 writes 0x0000000F to addr 0x000000FF with the slave ready -> grant=01 one cycle later, the write lands on m, s0 gets bresp=OKAY, and FSM is IDLE 1 cycle after the B handshake.
REQ-030 SHALL cover split AW/W: s1 asserts awvalid at cycle 0 and wvalid at cycle 3 -> m.awvalid drops after the AW handshake, WR_RESP is entered only after W completes, and grant=10 throughout.
REQ-031 SHALL cover simultaneous requests: s0 read and s1 write asserted in the same cycle, back-to-back, from reset -> order s0, s1, s0, s1 (round-robin); with AXI_ARB_FIXED_PRIO_EN, s0 is served on every arbitration while it requests.
REQ-032 SHALL cover write-over-read: s0 asserts awvalid and arvalid together -> write completes first, then read is arbitrated on the next IDLE and returns the rdata supplied by the slave (e.g. 0xDEADBEEF).
REQ-033 SHALL cover reset mid-operation: rstn=0 in RD_DATA with rvalid stalled -> next cycle grant=00, busy=0, all valids 0; after release a new s1 read is granted normally.
REQ-034 SHALL cover isolation: while s0 owns the bus, s1 holds awvalid high -> s1 awready, wready and bvalid stay 0 throughout.
